// File: rtl/packet_sender_rr.sv
// Round-robin multi-channel packet sender: streams SRC, DST, SIZE, DATA..., CRC
// from NCH random-access input buffers onto one valid/ready byte link.
module packet_sender_rr #(
    parameter int UWIDTH    = 8,
    parameter int PTR_IN_SZ = 4,
    parameter int SIZE_BITS = 3,
    parameter int NCH       = 2,
    parameter int CH_BITS   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0]          rempty,
    input  logic [NCH*UWIDTH-1:0]   rdata,
    output logic [NCH-1:0]          rinc,
    output logic [PTR_IN_SZ-1:0]    raddr_in,
    output logic [UWIDTH-1:0]       packet_out,
    output logic                    packet_valid,
    output logic                    packet_sop,
    output logic                    packet_eop,
    output logic [CH_BITS-1:0]      packet_ch,
    input  logic                    packet_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [PTR_IN_SZ-1:0] raddr_q, raddr_d;
    logic [PTR_IN_SZ-1:0] last_addr_q, last_addr_d;
    logic                 size_seen_q, size_seen_d;
    logic [NCH-1:0]       rinc_q, rinc_d;
    logic [CH_BITS-1:0]   ch_q, ch_d;
    logic [CH_BITS-1:0]   last_grant_q, last_grant_d;

    logic [NCH-1:0]       eligible;
    logic                 grant_found;
    logic [CH_BITS-1:0]   grant;
    logic                 accept;
    logic [SIZE_BITS-1:0] size_low;

    function automatic logic [CH_BITS-1:0] rr_index(input logic [CH_BITS-1:0] base,
                                                    input int unsigned off);
        int unsigned sum;
        sum = (32'(base) + off) % NCH;
        return CH_BITS'(sum);
    endfunction

    assign packet_out   = rdata[ch_q*UWIDTH +: UWIDTH];
    assign packet_valid = (state_q == SEND);
    assign packet_sop   = packet_valid && (raddr_q == '0);
    assign packet_eop   = packet_valid && size_seen_q && (raddr_q == last_addr_q);
    assign packet_ch    = ch_q;
    assign raddr_in     = raddr_q;
    assign rinc         = rinc_q;
    assign accept       = packet_valid && packet_ready;
    assign size_low     = packet_out[SIZE_BITS-1:0];

    // The channel whose packet is being released this cycle is not yet empty
    // in its buffer's view, so it is masked from arbitration.
    always_comb begin
        eligible    = ~rempty & ~rinc_q;
        grant_found = 1'b0;
        grant       = last_grant_q;
        for (int unsigned i = 1; i <= NCH; i++) begin
            if (!grant_found && eligible[rr_index(last_grant_q, i)]) begin
                grant_found = 1'b1;
                grant       = rr_index(last_grant_q, i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        raddr_d      = raddr_q;
        last_addr_d  = last_addr_q;
        size_seen_d  = size_seen_q;
        rinc_d       = '0;
        ch_d         = ch_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    state_d      = SEND;
                    ch_d         = grant;
                    last_grant_d = grant;
                end
            end
            default: begin
                if (accept) begin
                    raddr_d = raddr_q + PTR_IN_SZ'(1);
                    if (raddr_q == PTR_IN_SZ'(2)) begin
                        last_addr_d = PTR_IN_SZ'(3) + PTR_IN_SZ'(size_low);
                        size_seen_d = 1'b1;
                    end
                    if (packet_eop) begin
                        state_d      = IDLE;
                        raddr_d      = '0;
                        size_seen_d  = 1'b0;
                        rinc_d[ch_q] = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            raddr_q      <= '0;
            last_addr_q  <= '0;
            size_seen_q  <= 1'b0;
            rinc_q       <= '0;
            ch_q         <= '0;
            last_grant_q <= CH_BITS'(NCH - 1);
        end else begin
            state_q      <= state_d;
            raddr_q      <= raddr_d;
            last_addr_q  <= last_addr_d;
            size_seen_q  <= size_seen_d;
            rinc_q       <= rinc_d;
            ch_q         <= ch_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_packet_sender_rr.sv
// Directed bench for packet_sender_rr: buffer model per channel, packet-level
// scoreboard checked every cycle, plus hand-computed timing expectations.
module tb_packet_sender_rr;

    typedef struct packed {
        logic [0:0]       ch;
        logic [10:0][7:0] b;
    } pkt_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rempty;
    logic [15:0] rdata;
    logic [1:0]  rinc;
    logic [3:0]  raddr_in;
    logic [7:0]  packet_out;
    logic        packet_valid, packet_sop, packet_eop;
    logic [0:0]  packet_ch;
    logic        packet_ready;

    logic [7:0] mem [2][4][16];
    logic [7:0] wr_cnt [2];
    logic [7:0] rd_cnt [2] = '{8'd0, 8'd0};

    pkt_t exp_q[$];
    int   sop_ch_q[$];
    int   gap_q[$];
    int   n_tests = 0, n_fail = 0;
    int   cyc = 0;
    int   beat = 0;
    int   valid_cycles = 0, rinc_pulses = 0, dst_cycles = 0;
    int   sop_cyc = 0, eop_cyc = -100, eop_raddr = 0, rinc_cyc = 0;
    logic prev_eop = 1'b0;
    logic [1:0] exp_rinc = '0;

    packet_sender_rr #(
        .UWIDTH(8), .PTR_IN_SZ(4), .SIZE_BITS(3), .NCH(2), .CH_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .raddr_in(raddr_in), .packet_out(packet_out), .packet_valid(packet_valid),
        .packet_sop(packet_sop), .packet_eop(packet_eop), .packet_ch(packet_ch),
        .packet_ready(packet_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Input buffers: release the head packet on the edge that samples rinc.
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++)
            if (rinc[c]) rd_cnt[c] <= rd_cnt[c] + 8'd1;
    end

    always_comb begin
        rdata  = '0;
        rempty = '0;
        for (int c = 0; c < 2; c++) begin
            rdata[c*8 +: 8] = mem[c][rd_cnt[c][1:0]][raddr_in];
            rempty[c]       = (wr_cnt[c] == rd_cnt[c]);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic pkt_t mk(input int ch, input logic [7:0] src, input logic [7:0] dst,
                                input logic [7:0] size, input logic [7:0] dbase,
                                input logic [7:0] crc);
        pkt_t p;
        int   n;
        p      = '0;
        p.ch   = ch[0];
        n      = int'(size[2:0]);
        p.b[0] = src;
        p.b[1] = dst;
        p.b[2] = size;
        for (int i = 0; i < n; i++) p.b[3+i] = dbase + 8'(i);
        p.b[n+3] = crc;
        return p;
    endfunction

    task automatic load(input pkt_t p);
        for (int a = 0; a < 16; a++)
            mem[p.ch][wr_cnt[p.ch][1:0]][a] = (a < 11) ? p.b[a] : 8'h00;
        wr_cnt[p.ch] = wr_cnt[p.ch] + 8'd1;
    endtask

    task automatic wait_idle(input int max_cyc);
        int i;
        for (i = 0; i < max_cyc; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !packet_valid) break;
        end
        if (i == max_cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d packets outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Scoreboard: each packet is N+4 beats (N = SIZE[2:0]) at addresses 0..N+3,
    // the beat index advances only on accept, and a release pulse follows eop.
    task automatic checker_loop();
        pkt_t       pk;
        int         len;
        logic       nxt_eop;
        logic [1:0] nxt_rinc;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_valid", packet_valid, 0);
                chk("rst_rinc", rinc, 0);
                chk("rst_raddr", raddr_in, 0);
                chk("rst_sop", packet_sop, 0);
                chk("rst_eop", packet_eop, 0);
                chk("rst_ch", packet_ch, 0);
                beat     = 0;
                exp_rinc = '0;
                prev_eop = 1'b0;
            end else begin
                nxt_eop  = 1'b0;
                nxt_rinc = '0;
                chk("rinc", rinc, exp_rinc);
                if (rinc != 0) begin
                    rinc_pulses++;
                    rinc_cyc = cyc;
                end
                if (prev_eop) chk("gap_after_eop", packet_valid, 0);
                if (packet_valid) begin
                    valid_cycles++;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_valid: got valid=1, expected 0 (cycle %0d)", cyc);
                    end else begin
                        pk  = exp_q[0];
                        len = int'(pk.b[2][2:0]) + 4;
                        chk("ch", packet_ch, pk.ch);
                        chk("raddr", raddr_in, beat);
                        chk("data", packet_out, pk.b[beat]);
                        chk("sop", packet_sop, beat == 0);
                        chk("eop", packet_eop, beat == len - 1);
                        if (raddr_in == 4'd1) dst_cycles++;
                        if (packet_ready) begin
                            if (beat == 0) begin
                                sop_ch_q.push_back(int'(pk.ch));
                                gap_q.push_back(cyc - eop_cyc);
                                sop_cyc = cyc;
                            end
                            if (beat == len - 1) begin
                                nxt_eop          = 1'b1;
                                nxt_rinc[pk.ch]  = 1'b1;
                                eop_cyc          = cyc;
                                eop_raddr        = int'(raddr_in);
                                void'(exp_q.pop_front());
                                beat             = 0;
                            end else begin
                                beat++;
                            end
                        end
                    end
                end else if (beat != 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dropped_valid: got valid=0 at beat %0d, expected 1", beat);
                end
                prev_eop = nxt_eop;
                exp_rinc = nxt_rinc;
            end
        end
    endtask

    initial begin
        pkt_t p;
        int   t0, v0, r0, d0, s0, g0, i;

        packet_ready = 1'b1;
        wr_cnt[0] = '0;
        wr_cnt[1] = '0;
        for (int c = 0; c < 2; c++)
            for (int s = 0; s < 4; s++)
                for (int a = 0; a < 16; a++) mem[c][s][a] = '0;
        fork
            checker_loop();
        join_none
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Single ch0 packet with ready high
        @(posedge clk); #1;
        p = mk(0, 8'h11, 8'h22, 8'h02, 8'hA0, 8'h5C);
        chk("model_beat5", p.b[5], 8'h5C);
        t0 = cyc; v0 = valid_cycles; r0 = rinc_pulses;
        load(p); exp_q.push_back(p);
        wait_idle(40);
        chk("t1_sop_latency", sop_cyc - t0, 1);
        chk("t1_valid_cycles", valid_cycles - v0, 6);
        chk("t1_eop_raddr", eop_raddr, 5);
        chk("t1_rinc_after_eop", rinc_cyc - eop_cyc, 1);
        chk("t1_rinc_pulses", rinc_pulses - r0, 1);

        // Same packet, ready low for two cycles on the DST beat
        @(posedge clk); #1;
        v0 = valid_cycles; r0 = rinc_pulses; d0 = dst_cycles;
        load(p); exp_q.push_back(p);
        @(posedge clk); #1;
        @(posedge clk); #1 packet_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1 packet_ready = 1'b1;
        wait_idle(40);
        chk("t2_dst_cycles", dst_cycles - d0, 3);
        chk("t2_valid_cycles", valid_cycles - v0, 8);
        chk("t2_rinc_pulses", rinc_pulses - r0, 1);

        // Fresh priority, both channels loaded with three packets each
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        s0 = sop_ch_q.size(); g0 = gap_q.size();
        load(mk(0, 8'h01, 8'h02, 8'h01, 8'hB0, 8'hC1));
        load(mk(0, 8'h03, 8'h04, 8'h02, 8'hB4, 8'hC2));
        load(mk(0, 8'h05, 8'h06, 8'h03, 8'hB8, 8'hC3));
        load(mk(1, 8'h21, 8'h22, 8'h00, 8'hE0, 8'hD1));
        load(mk(1, 8'h23, 8'h24, 8'h04, 8'hE4, 8'hD2));
        load(mk(1, 8'h25, 8'h26, 8'h02, 8'hE8, 8'hD3));
        exp_q.push_back(mk(0, 8'h01, 8'h02, 8'h01, 8'hB0, 8'hC1));
        exp_q.push_back(mk(1, 8'h21, 8'h22, 8'h00, 8'hE0, 8'hD1));
        exp_q.push_back(mk(0, 8'h03, 8'h04, 8'h02, 8'hB4, 8'hC2));
        exp_q.push_back(mk(1, 8'h23, 8'h24, 8'h04, 8'hE4, 8'hD2));
        exp_q.push_back(mk(0, 8'h05, 8'h06, 8'h03, 8'hB8, 8'hC3));
        exp_q.push_back(mk(1, 8'h25, 8'h26, 8'h02, 8'hE8, 8'hD3));
        wait_idle(200);
        chk("t3_sop_count", sop_ch_q.size() - s0, 6);
        for (int k = 0; k < 6 && s0 + k < sop_ch_q.size(); k++)
            chk("t3_grant_order", sop_ch_q[s0+k], k % 2);
        for (int k = 1; k < 6 && g0 + k < gap_q.size(); k++)
            chk("t3_gap", gap_q[g0+k], 2);

        // SIZE boundaries: zero payload, then all-ones SIZE byte
        @(posedge clk); #1;
        v0 = valid_cycles;
        p = mk(0, 8'h31, 8'h32, 8'h00, 8'h00, 8'h3C);
        load(p); exp_q.push_back(p);
        wait_idle(40);
        chk("t4_size0_eop_raddr", eop_raddr, 3);
        chk("t4_size0_valid_cycles", valid_cycles - v0, 4);
        @(posedge clk); #1;
        v0 = valid_cycles;
        p = mk(1, 8'h41, 8'h42, 8'hFF, 8'h50, 8'h4C);
        chk("model_size_ff_crc", p.b[10], 8'h4C);
        load(p); exp_q.push_back(p);
        wait_idle(40);
        chk("t4_sizeff_eop_raddr", eop_raddr, 10);
        chk("t4_sizeff_valid_cycles", valid_cycles - v0, 11);

        // Only ch1, two packets back to back: masked for one cycle after release
        @(posedge clk); #1;
        r0 = rinc_pulses; g0 = gap_q.size();
        p = mk(1, 8'h61, 8'h62, 8'h01, 8'h70, 8'h6C); load(p); exp_q.push_back(p);
        p = mk(1, 8'h63, 8'h64, 8'h02, 8'h78, 8'h6D); load(p); exp_q.push_back(p);
        wait_idle(60);
        chk("t5_sop_count", gap_q.size() - g0, 2);
        if (gap_q.size() >= g0 + 2) chk("t5_same_ch_gap", gap_q[g0+1], 3);
        chk("t5_rinc_pulses", rinc_pulses - r0, 2);

        // Reset during the third DATA beat aborts without release, then resends
        @(posedge clk); #1;
        r0 = rinc_pulses; s0 = sop_ch_q.size();
        p = mk(0, 8'h71, 8'h72, 8'h04, 8'hD0, 8'h7C);
        load(p); exp_q.push_back(p);
        for (i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (beat == 5) break;
        end
        if (i == 30) begin
            n_tests++;
            n_fail++;
            $display("FAIL t6_reach_data3: got beat %0d, expected 5", beat);
        end
        chk("t6_pre_raddr", raddr_in, 5);
        rst = 1'b0;
        #1;
        chk("t6_now_valid", packet_valid, 0);
        chk("t6_now_raddr", raddr_in, 0);
        chk("t6_now_rinc", rinc, 0);
        chk("t6_now_sop", packet_sop, 0);
        chk("t6_now_eop", packet_eop, 0);
        chk("t6_now_ch", packet_ch, 0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        wait_idle(60);
        chk("t6_sop_count", sop_ch_q.size() - s0, 2);
        chk("t6_eop_raddr", eop_raddr, 7);
        chk("t6_rinc_pulses", rinc_pulses - r0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_sender_rr.md
# packet_sender_rr

Multi-channel successor of the single-buffer packet sender. Reads complete packets (SRC, DST, SIZE, DATA…, CRC) out of NCH random-access input packet buffers and streams them byte-serially onto one output link. Channels are selected by round-robin arbitration, and the output has valid/ready backpressure. Sits between the per-port input buffers and the router crossbar/output link; runs on a single clock edge and keeps the gap between packets to one cycle.

## Interface
- UWIDTH, 8: byte/word width of buffer data and link.
- PTR_IN_SZ, 4: buffer read-address width; must satisfy 2^SIZE_BITS + 3 ≤ 2^PTR_IN_SZ − 1.
- SIZE_BITS, 3: low bits of the SIZE byte giving the payload count N (0…2^SIZE_BITS−1).
- NCH, 2: number of input channels (≥2).
- CH_BITS, 1: channel index width; NCH ≤ 2^CH_BITS.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- rempty  in  NCH  per-channel "no complete packet buffered".
- rdata  in  NCH*UWIDTH  channel c byte at bits [c*UWIDTH +: UWIDTH]; combinational read of that buffer at raddr_in.
- rinc  out  NCH  one-cycle pulse: release the packet of channel c.
- raddr_in  out  PTR_IN_SZ  shared read address, meaningful only for the granted channel.
- packet_out  out  UWIDTH  rdata of the granted channel (combinational mux).
- packet_valid  out  1  beat on packet_out is valid.
- packet_sop / packet_eop  out  1  first / last beat of the packet, qualified by packet_valid.
- packet_ch  out  CH_BITS  granted channel index.
- packet_ready  in  1  downstream accepts the beat this cycle.

## Operation
- Buffer layout per packet: addr 0 SRC, 1 DST, 2 SIZE, 3…N+2 DATA, N+3 CRC; N+4 beats in total.
- States: IDLE, SEND.
- IDLE: packet_valid=0, raddr_in=0. Eligible = ~rempty & ~rinc, i.e. the channel being released this cycle is masked. If any channel is eligible, grant the first eligible channel after last_grant (cyclic), load packet_ch, last_grant := grant, and go to SEND.
- SEND: packet_valid=1. Accept = packet_valid & packet_ready. Each accept: raddr_in+1. With packet_ready=0, raddr_in, packet_ch and the state hold.
- Accept with raddr_in==2: latch last_addr := 3 + rdata[SIZE_BITS-1:0], zero-extended to PTR_IN_SZ and added without overflow (guaranteed by the parameter rule). Set size_seen. Upper SIZE bits are ignored.
- packet_sop = SEND & raddr_in==0.
- packet_eop = SEND & size_seen & raddr_in==last_addr.
- Accept with eop: next state IDLE, raddr_in:=0, size_seen:=0, rinc[packet_ch]:=1 for exactly the next cycle.
- Input buffers must update rempty on the same edge that samples rinc.
- rempty is ignored during SEND. A channel's rempty deasserting mid-packet has no effect.
- Reset values: state IDLE, raddr_in 0, rinc 0, packet_valid 0, packet_sop 0, packet_eop 0, packet_ch 0, size_seen 0, last_addr 0, last_grant NCH−1 (channel 0 has first priority).
- Reset mid-packet: the packet is aborted with no rinc. The buffer retains it, and it is re-sent from addr 0 after reset.

## Timing
- rempty[c] falls at cycle t while IDLE → first beat (sop) valid at t+1.
- Packet of N payload bytes with ready held high: N+4 consecutive valid cycles.
- eop accepted at cycle e → rinc pulse at e+1, IDLE at e+1.
  - Next packet from another channel: valid at e+2 (one-cycle gap).
  - Next packet from the same channel: earliest valid at e+3, since that channel is masked at e+1.
- Backpressure adds exactly one cycle per ready-low cycle. Outputs stay stable while stalled.
- packet_out path is combinational from raddr_in through the buffer to the mux, with no added latency.

## Test plan
- Ch0 packet SRC=0x11, DST=0x22, SIZE=0x02, D=0xA0, 0xA1, CRC=0x5C, ready=1 → six beats in order, sop on beat 1, eop on beat 6 at raddr 5, packet_ch=0, rinc=01 one cycle after eop.
- Same packet with ready low for 2 cycles at the DST beat → DST held 3 cycles, raddr_in stays 1, total 8 valid cycles, exactly one rinc pulse.
- Both channels always non-empty, 3 packets each → grant order 0,1,0,1,0,1; one valid-low cycle between packets; packet_ch matches.
- SIZE=0x00 → 4 beats, eop at raddr 3. SIZE=0xFF (N=7) → 11 beats, eop at raddr 10, upper bits ignored.
- Only ch1 with two queued packets → second sop exactly 3 cycles after first eop. rinc never pulses while ch1 is masked.
- rst low at the third DATA beat → all outputs at reset values immediately. After release, the same channel's packet is resent from SRC, with no rinc before its eop.
